spi_target_port: RTL and testbench
==================================

// Module: spi_target_port
// PURPOSE
//   SPI mode-0 target (responder) that lets an external SPI host exchange bytes with the RISC-V SoC.
//   Sits beside the SPI initiator blocks in the system core on a PMOD pin set.
//   Pins are oversampled in the system clock domain.
//   Received bytes go into a small RX FIFO; transmit bytes come from a one-deep holding register that the CPU writes.
// PARAMETERS
//   SYNC_STAGES  2      synchroniser depth on spi_sclk/spi_cs_n/spi_mosi (>=2)
//   FIFO_AW      2      RX FIFO address width; depth = 2**FIFO_AW
//   IDLE_BYTE    8'hFF  byte shifted out when the TX holding register is empty
// PORTS
//   clk          in   1  system clock; must be >= 4x spi_sclk
//   reset        in   1  asynchronous, active-high
//   spi_sclk     in   1  SPI clock from host (CPOL=0)
//   spi_cs_n     in   1  chip select, active-low
//   spi_mosi     in   1  host->target data
//   spi_miso     out  1  target->host data
//   spi_miso_oe  out  1  MISO output enable (1 while selected)
//   rx_data      out  8  RX FIFO head byte
//   rx_valid     out  1  RX FIFO non-empty
//   rx_ready     in   1  pop RX FIFO when rx_valid & rx_ready
//   tx_data      in   8  next byte to transmit
//   tx_load      in   1  write tx_data into holding register
//   tx_empty     out  1  holding register empty
//   rx_overrun   out  1  sticky: a received byte was dropped because the FIFO was full
//   ovr_clr      in   1  clear rx_overrun
//   xfer_done    out  1  one-clk pulse per completed byte
// BEHAVIOUR
//   Reset values
//   - spi_miso=0, spi_miso_oe=0, rx_valid=0, rx_data=0, tx_empty=1, rx_overrun=0, xfer_done=0.
//   - FIFO pointers = 0, bit_cnt = 0.
//   - Synchroniser flops reset to sclk=0, cs_n=1, mosi=0.
//   Sampling and edges
//   - All SPI inputs pass through SYNC_STAGES flops.
//   - Edges are detected against one extra registered copy: rise = s & ~s_d, fall = ~s & s_d.
//   - spi_miso_oe = ~cs_sync (registered).
//   - SCLK edges while cs_sync=1 are ignored.
//   Select (cs_sync falling edge)
//   - bit_cnt <= 0.
//   - tx_shift <= holding if !tx_empty (then tx_empty <= 1), else IDLE_BYTE.
//   - spi_miso <= that byte's bit 7.
//   SCLK rising edge
//   - rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt <= bit_cnt + 1 (3-bit, wraps 7->0).
//   - On the 8th rise (bit_cnt==7), in the same clk:
//     - push {rx_shift[6:0], mosi_sync} into the FIFO;
//     - xfer_done = 1 for one clk.
//   - The pushed byte is visible at rx_data/rx_valid on the next clk.
//   SCLK falling edge, bit_cnt != 0
//   - tx_shift <= tx_shift << 1; spi_miso <= tx_shift[6].
//   SCLK falling edge, bit_cnt == 0 (byte boundary)
//   - Reload tx_shift from the holding register (or IDLE_BYTE) using the same rule as select.
//   - spi_miso <= new bit 7.
//   - Data is MSB first in both directions.
//   Holding register
//   - tx_load sets holding = tx_data and tx_empty = 0; loading while full overwrites.
//   - tx_load in the same clk as a consume: the old byte is consumed, the new byte is stored, tx_empty = 0.
//   RX FIFO
//   - rx_data = head entry.
//   - Push while full (and no pop in the same clk): byte dropped, rx_overrun <= 1.
//   - Push and pop in the same clk when full: pop first, push accepted, no overrun.
//   - ovr_clr clears rx_overrun; a new overrun in the same clk wins (flag stays 1).
//   Deselect (cs_sync rising edge) mid-byte
//   - Partial byte discarded, no push, bit_cnt <= 0, spi_miso <= 0.
//   - A holding byte consumed at the start of the aborted byte is not restored.
//   Reset mid-transfer
//   - All state returns to reset values immediately; the host must reselect afterwards.
// TESTING
//   1. Send 0xA5 with holding=0x3C (clk=24MHz, sclk=3MHz)
//      -> host reads 0x3C on MISO; rx_data=0xA5; rx_valid=1; xfer_done one pulse; tx_empty=1.
//   2. Two-byte burst 0x01,0x02 with holding empty
//      -> host reads 0xFF,0xFF; FIFO pops in order 0x01 then 0x02.
//   3. Send 5 bytes with FIFO_AW=2 and rx_ready=0
//      -> first 4 bytes retained; rx_overrun=1 until ovr_clr.
//   4. Deassert cs_n after 5 SCLKs, then send 0x81
//      -> only 0x81 in FIFO; bit alignment correct.
//   5. tx_load in the same clk as the byte-boundary reload
//      -> old byte shifts out, new byte is held, tx_empty=0.
//   6. Assert reset mid-byte -> all outputs at reset values within 1 clk; a subsequent clean transfer works.

Source files
------------

// File: rtl/spi_target_port_if.sv
// spi_target_port_if: SPI pins plus CPU-side RX FIFO / TX holding register signals
interface spi_target_port_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_empty;
  logic       rx_overrun;
  logic       ovr_clr;
  logic       xfer_done;
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, rx_ready, tx_data, tx_load, ovr_clr,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_empty, rx_overrun, xfer_done
  );
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, rx_ready, tx_data, tx_load, ovr_clr,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_empty, rx_overrun, xfer_done
  );
endinterface

// File: rtl/spi_target_port.sv
// spi_target_port: oversampled SPI mode-0 target with RX FIFO and one-deep TX holding register
module spi_target_port #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FIFO_AW     = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input logic           clk,
  input logic           reset,
  spi_target_port_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d_q, cs_d_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, reload, push, pop, full, empty, push_ok;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, hold_q, hold_d, next_byte, rx_byte;
  logic miso_q, miso_d, oe_q, tx_empty_q, tx_empty_d, ovr_q, ovr_d, done_q;
  logic [FIFO_AW:0] wp_q, rp_q;
  logic [7:0] mem_q [DEPTH];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_d_q & ~cs_s;
  assign cs_fall   = ~cs_s & cs_d_q;
  assign cs_rise   = cs_s & ~cs_d_q;
  // A new TX byte is taken at select and at every byte boundary falling edge
  assign reload    = cs_fall | (sclk_fall & (bit_cnt_q == 3'd0));
  assign next_byte = tx_empty_q ? IDLE_BYTE : hold_q;
  assign rx_byte   = {rx_shift_q[6:0], mosi_s};
  assign push      = sclk_rise & (bit_cnt_q == 3'd7);
  assign empty     = wp_q == rp_q;
  assign full      = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) && (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign pop       = ~empty & bus.rx_ready;
  // A full FIFO still accepts a push when a pop frees a slot in the same clk
  assign push_ok   = push & (~full | pop);
  assign tx_empty_d = bus.tx_load ? 1'b0 : (reload ? 1'b1 : tx_empty_q);
  assign hold_d     = bus.tx_load ? bus.tx_data : hold_q;
  assign ovr_d      = (push & full & ~pop) | (ovr_q & ~bus.ovr_clr);
  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.rx_data     = mem_q[rp_q[FIFO_AW-1:0]];
  assign bus.rx_valid    = ~empty;
  assign bus.tx_empty    = tx_empty_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.xfer_done   = done_q;
  // Shift engine next state: deselect aborts, select/boundary reloads, rise samples, fall shifts
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    if (cs_rise) begin
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (reload) begin
      bit_cnt_d  = 3'd0;
      tx_shift_d = next_byte;
      miso_d     = next_byte[7];
    end else if (sclk_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end else if (sclk_fall) begin
      tx_shift_d = tx_shift_q << 1;
      miso_d     = tx_shift_q[6];
    end
  end
  // Input synchronisers and the extra copies used for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q   <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      sclk_d_q <= 1'b0;
      cs_d_q   <= 1'b1;
    end else begin
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_q     <= {cs_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_d_q <= sclk_s;
      cs_d_q   <= cs_s;
    end
  end
  // Shift registers, holding register, status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      hold_q     <= 8'h00;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      tx_empty_q <= 1'b1;
      ovr_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      hold_q     <= hold_d;
      miso_q     <= miso_d;
      oe_q       <= ~cs_s;
      tx_empty_q <= tx_empty_d;
      ovr_q      <= ovr_d;
      done_q     <= push;
    end
  end
  // RX FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push_ok) mem_q[wp_q[FIFO_AW-1:0]] <= rx_byte;
      wp_q <= push_ok ? wp_q + (FIFO_AW+1)'(1) : wp_q;
      rp_q <= pop ? rp_q + (FIFO_AW+1)'(1) : rp_q;
    end
  end
endmodule

// File: tb/tb_spi_target_port.sv
// tb_spi_target_port: directed SPI host sequences with hand-computed expectations
module tb_spi_target_port;
  localparam int H = 50;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int d0;
  logic [7:0] mi;
  spi_target_port_if bus();
  spi_target_port dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.xfer_done === 1'b1) done_cnt++;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic sel();
    bus.spi_cs_n = 1'b0;
    #(2*H);
  endtask
  task automatic desel();
    bus.spi_cs_n = 1'b1;
    #(2*H);
  endtask
  task automatic load(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_load = 1'b1;
    #10;
    bus.tx_load = 1'b0;
    #10;
  endtask
  task automatic xfer(input logic [7:0] mo, output logic [7:0] mr, input bit ld, input logic [7:0] ld_byte);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = mo[i];
      #H;
      mr[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      #H;
      bus.spi_sclk = 1'b0;
    end
    if (ld) begin
      #20;
      bus.tx_data = ld_byte;
      bus.tx_load = 1'b1;
      #10;
      bus.tx_load = 1'b0;
      #(H-30);
    end else begin
      #H;
    end
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, " valid"}, {7'd0, bus.rx_valid}, 8'd1);
    chk({tag, " data"}, bus.rx_data, exp);
    bus.rx_ready = 1'b1;
    #10;
    bus.rx_ready = 1'b0;
    #10;
  endtask
  initial begin
    reset = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.rx_ready = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    bus.ovr_clr = 1'b0;
    #20;
    chk("rst miso", {7'd0, bus.spi_miso}, 8'd0);
    chk("rst oe", {7'd0, bus.spi_miso_oe}, 8'd0);
    chk("rst rx_valid", {7'd0, bus.rx_valid}, 8'd0);
    chk("rst rx_data", bus.rx_data, 8'h00);
    chk("rst tx_empty", {7'd0, bus.tx_empty}, 8'd1);
    chk("rst overrun", {7'd0, bus.rx_overrun}, 8'd0);
    chk("rst xfer_done", {7'd0, bus.xfer_done}, 8'd0);
    reset = 1'b0;
    #40;
    load(8'h3C);
    chk("t1 tx_empty loaded", {7'd0, bus.tx_empty}, 8'd0);
    d0 = done_cnt;
    sel();
    chk("t1 oe", {7'd0, bus.spi_miso_oe}, 8'd1);
    chk("t1 tx_empty consumed", {7'd0, bus.tx_empty}, 8'd1);
    xfer(8'hA5, mi, 1'b0, 8'h00);
    chk("t1 miso byte", mi, 8'h3C);
    chk("t1 done pulses", 8'(done_cnt - d0), 8'd1);
    pop_chk("t1 pop", 8'hA5);
    chk("t1 drained", {7'd0, bus.rx_valid}, 8'd0);
    xfer(8'h01, mi, 1'b0, 8'h00);
    chk("t2 miso b0", mi, 8'hFF);
    xfer(8'h02, mi, 1'b0, 8'h00);
    chk("t2 miso b1", mi, 8'hFF);
    desel();
    chk("t2 oe off", {7'd0, bus.spi_miso_oe}, 8'd0);
    pop_chk("t2 pop0", 8'h01);
    pop_chk("t2 pop1", 8'h02);
    d0 = done_cnt;
    sel();
    for (int k = 0; k < 5; k++) xfer(8'h10 + 8'(k), mi, 1'b0, 8'h00);
    desel();
    chk("t3 done pulses", 8'(done_cnt - d0), 8'd5);
    chk("t3 overrun set", {7'd0, bus.rx_overrun}, 8'd1);
    for (int k = 0; k < 4; k++) pop_chk("t3 pop", 8'h10 + 8'(k));
    chk("t3 drained", {7'd0, bus.rx_valid}, 8'd0);
    chk("t3 overrun sticky", {7'd0, bus.rx_overrun}, 8'd1);
    bus.ovr_clr = 1'b1;
    #10;
    bus.ovr_clr = 1'b0;
    #10;
    chk("t3 overrun cleared", {7'd0, bus.rx_overrun}, 8'd0);
    sel();
    for (int k = 0; k < 5; k++) begin
      bus.spi_mosi = 1'b1;
      #H;
      bus.spi_sclk = 1'b1;
      #H;
      bus.spi_sclk = 1'b0;
    end
    #H;
    chk("t4 miso mid-byte", {7'd0, bus.spi_miso}, 8'd1);
    desel();
    chk("t4 miso aborted", {7'd0, bus.spi_miso}, 8'd0);
    chk("t4 no push", {7'd0, bus.rx_valid}, 8'd0);
    sel();
    xfer(8'h81, mi, 1'b0, 8'h00);
    desel();
    pop_chk("t4 pop", 8'h81);
    chk("t4 drained", {7'd0, bus.rx_valid}, 8'd0);
    load(8'h11);
    sel();
    load(8'h22);
    chk("t5 holding full", {7'd0, bus.tx_empty}, 8'd0);
    xfer(8'h55, mi, 1'b1, 8'h33);
    chk("t5 miso b0", mi, 8'h11);
    chk("t5 new byte held", {7'd0, bus.tx_empty}, 8'd0);
    xfer(8'h66, mi, 1'b0, 8'h00);
    chk("t5 miso old byte", mi, 8'h22);
    xfer(8'h77, mi, 1'b0, 8'h00);
    chk("t5 miso new byte", mi, 8'h33);
    chk("t5 holding drained", {7'd0, bus.tx_empty}, 8'd1);
    desel();
    pop_chk("t5 pop0", 8'h55);
    pop_chk("t5 pop1", 8'h66);
    pop_chk("t5 pop2", 8'h77);
    sel();
    xfer(8'hE7, mi, 1'b0, 8'h00);
    load(8'h5A);
    for (int k = 0; k < 3; k++) begin
      bus.spi_mosi = 1'b0;
      #H;
      bus.spi_sclk = 1'b1;
      #H;
      bus.spi_sclk = 1'b0;
    end
    #H;
    chk("t6 pre miso", {7'd0, bus.spi_miso}, 8'd1);
    chk("t6 pre rx_valid", {7'd0, bus.rx_valid}, 8'd1);
    reset = 1'b1;
    #1;
    chk("t6 rst miso", {7'd0, bus.spi_miso}, 8'd0);
    chk("t6 rst oe", {7'd0, bus.spi_miso_oe}, 8'd0);
    chk("t6 rst rx_valid", {7'd0, bus.rx_valid}, 8'd0);
    chk("t6 rst rx_data", bus.rx_data, 8'h00);
    chk("t6 rst tx_empty", {7'd0, bus.tx_empty}, 8'd1);
    #9;
    bus.spi_cs_n = 1'b1;
    #20;
    reset = 1'b0;
    #40;
    load(8'h96);
    sel();
    xfer(8'hC3, mi, 1'b0, 8'h00);
    desel();
    chk("t6 miso after reset", mi, 8'h96);
    pop_chk("t6 pop", 8'hC3);
    chk("t6 drained", {7'd0, bus.rx_valid}, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
